// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the pushbutton debouncer.
//   key_state_e      : per-channel FSM state
//   DEF_*_CYC        : default cycle counts for a 50 MHz clock
//   max3()           : largest of three cycle counts, used to size counters
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEF_DEBOUNCE_CYC      = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY_CYC  = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD_CYC = 5000000;   // 100 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel -- debounce FSM, level/pulse generation and auto-repeat for one key.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_pressed      : synchronized key state, 1 = pressed
//   o_level        : debounced state, 1 = pressed
//   o_press        : one-cycle pulse on accepted press
//   o_release      : one-cycle pulse on accepted release
//   o_repeat       : one-cycle auto-repeat pulse while held
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
    parameter int REPEAT_EN         = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pressed,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC)) + 1;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD_CYC - 1);

    key_state_e       r_state;
    logic [CNT_W-1:0] r_dcnt;   // debounce counter, shared by press and release waits
    logic [CNT_W-1:0] r_rcnt;   // repeat counter, frozen outside HELD
    logic             r_first;  // next repeat uses the initial delay, not the period

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_dcnt    <= '0;
            r_rcnt    <= '0;
            r_first   <= 1'b0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_repeat  <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_repeat  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_pressed) begin
                        r_state <= PRESS_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!i_pressed) begin
                        r_state <= IDLE;
                    end else if (r_dcnt == DB_LAST) begin
                        r_state <= HELD;
                        o_level <= 1'b1;
                        o_press <= 1'b1;
                        r_rcnt  <= '0;
                        r_first <= 1'b1;
                    end else if (r_dcnt != '1) begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!i_pressed) begin
                        r_state <= RELEASE_WAIT;
                        r_dcnt  <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (r_rcnt == (r_first ? RD_LAST : RP_LAST)) begin
                            o_repeat <= 1'b1;
                            r_rcnt   <= '0;
                            r_first  <= 1'b0;
                        end else if (r_rcnt != '1) begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed resumes HELD silently; the repeat
                    // counter picks up where it stopped.
                    if (i_pressed) begin
                        r_state <= HELD;
                    end else if (r_dcnt == DB_LAST) begin
                        r_state   <= IDLE;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                    end else if (r_dcnt != '1) begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce -- synchronizers plus one debounce channel per pushbutton.
//   CLOCK_50    : clock
//   resetn      : asynchronous active-low reset
//   KEY         : raw pushbuttons, active-low
//   SW          : raw slide switches
//   key_level   : debounced key state, 1 = pressed
//   key_press   : one-cycle pulse per accepted press
//   key_release : one-cycle pulse per accepted release
//   key_repeat  : one-cycle auto-repeat pulse while held
//   sw_sync     : switches after a 2-flop synchronizer
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS            = 4,
    parameter int N_SW              = 10,
    parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
    parameter int REPEAT_EN         = 1
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] KEY,
    input  logic [N_SW-1:0]   SW,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic [N_SW-1:0]   sw_sync
);

    logic [N_KEYS-1:0] r_key_meta;
    logic [N_KEYS-1:0] r_key_sync;
    logic [N_SW-1:0]   r_sw_meta;
    logic [N_KEYS-1:0] w_pressed;

    // Key flops reset to 1 (released) so a key held through reset is seen
    // as a fresh press once reset lifts.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_key_meta <= '1;
            r_key_sync <= '1;
            r_sw_meta  <= '0;
            sw_sync    <= '0;
        end else begin
            r_key_meta <= KEY;
            r_key_sync <= r_key_meta;
            r_sw_meta  <= SW;
            sw_sync    <= r_sw_meta;
        end
    end

    assign w_pressed = ~r_key_sync;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYC      (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC),
            .REPEAT_EN         (REPEAT_EN)
        ) u_ch (
            .i_clk     (CLOCK_50),
            .i_rst_n   (resetn),
            .i_pressed (w_pressed[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g]),
            .o_repeat  (key_repeat[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce. Two instances: dut A with auto-repeat, dut B without.
// Expected pulses (dut, key, kind, cycle) go into a scoreboard queue when the
// stimulus is issued; a negedge monitor matches every pulse the DUTs present.
// Cycle numbering: cyc = number of rising edges so far; an input driven just
// after edge c is first sampled at edge c+1.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] key_a, key_b;
    logic [9:0] sw_a, sw_b;
    logic [3:0] a_lvl, a_prs, a_rel, a_rep;
    logic [3:0] b_lvl, b_prs, b_rel, b_rep;
    logic [9:0] a_sw, b_sw;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    key_debounce #(
        .N_KEYS(4), .N_SW(10), .DEBOUNCE_CYC(8), .REPEAT_DELAY_CYC(40),
        .REPEAT_PERIOD_CYC(10), .REPEAT_EN(1)
    ) u_dut_a (
        .CLOCK_50(clk), .resetn(resetn), .KEY(key_a), .SW(sw_a),
        .key_level(a_lvl), .key_press(a_prs), .key_release(a_rel),
        .key_repeat(a_rep), .sw_sync(a_sw)
    );

    key_debounce #(
        .N_KEYS(4), .N_SW(10), .DEBOUNCE_CYC(8), .REPEAT_DELAY_CYC(40),
        .REPEAT_PERIOD_CYC(10), .REPEAT_EN(0)
    ) u_dut_b (
        .CLOCK_50(clk), .resetn(resetn), .KEY(key_b), .SW(sw_b),
        .key_level(b_lvl), .key_press(b_prs), .key_release(b_rel),
        .key_repeat(b_rep), .sw_sync(b_sw)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // kind: 0 = press, 1 = release, 2 = repeat
    typedef struct {
        int d;
        int k;
        int kind;
        int c;
    } exp_t;
    exp_t sb[$];
    string kname[3] = '{"press", "release", "repeat"};

    task automatic expect_pulse(input int d, input int k, input int kind, input int c);
        exp_t e;
        e.d = d; e.k = k; e.kind = kind; e.c = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // {level, repeat, release, press} for one key of one DUT
    function automatic logic [3:0] bits_of(input int d, input int k);
        if (d == 0) return {a_lvl[k], a_rep[k], a_rel[k], a_prs[k]};
        return {b_lvl[k], b_rep[k], b_rel[k], b_prs[k]};
    endfunction

    always @(negedge clk) begin : monitor
        logic [3:0] p;
        int idx;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                p = bits_of(d, k);
                for (int kind = 0; kind < 3; kind++) begin
                    if (p[kind]) begin
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++)
                            if (idx < 0 && sb[i].d == d && sb[i].k == k &&
                                sb[i].kind == kind && sb[i].c == cyc)
                                idx = i;
                        n_chk++;
                        if (idx < 0) begin
                            n_fail++;
                            $display("FAIL pulse dut%0d key%0d %s: seen at cycle %0d, required none",
                                     d, k, kname[kind], cyc);
                        end else begin
                            sb.delete(idx);
                        end
                    end
                end
                if (p[2:0] != 3'b000) begin
                    n_chk++;
                    if ($countones(p[2:0]) > 1 || (p[2] && !p[3])) begin
                        n_fail++;
                        $display("FAIL exclusive dut%0d key%0d: {lvl,rep,rel,prs}=%b at cycle %0d, required one pulse with level for repeat",
                                 d, k, p, cyc);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        int c;
        resetn = 1'b0;
        key_a  = 4'hF;
        key_b  = 4'hF;
        sw_a   = 10'h3FF;
        sw_b   = 10'h000;

        // Reset state: outputs and synchronized switches held at 0.
        wait_until(2);
        chk("reset a_lvl", a_lvl, 0);
        chk("reset a_pulses", {a_prs, a_rel, a_rep}, 0);
        chk("reset b_lvl", b_lvl, 0);
        chk("reset a_sw", a_sw, 0);
        wait_until(3);
        sw_a   = 10'h000;
        resetn = 1'b1;

        // Clean press on KEY[0] held 100 cycles.
        wait_until(10);
        t0 = cyc + 1;
        key_a[0] = 1'b0;
        expect_pulse(0, 0, 0, t0 + 10);
        for (int r = 50; r <= 100; r += 10) expect_pulse(0, 0, 2, t0 + r);
        wait_until(t0 + 20);
        chk("clean lvl0 held", a_lvl[0], 1);
        wait_until(t0 + 100);
        key_a[0] = 1'b1;                       // first sampled at t0+101
        expect_pulse(0, 0, 1, t0 + 111);
        wait_until(t0 + 125);
        chk("clean lvl0 released", a_lvl[0], 0);

        // Bounce on KEY[1]: 3-cycle toggles for 30 cycles, then held low.
        t0 = cyc + 1;
        for (int i = 0; i < 30; i++) begin
            key_a[1] = (((i / 3) % 2) != 0);
            @(posedge clk);
            #1;
        end
        key_a[1] = 1'b0;                       // first sampled at t0+30
        expect_pulse(0, 1, 0, t0 + 40);
        chk("bounce lvl1 before accept", a_lvl[1], 0);
        wait_until(t0 + 44);
        key_a[1] = 1'b1;                       // first sampled at t0+45
        expect_pulse(0, 1, 1, t0 + 55);
        wait_until(t0 + 65);

        // Release glitch on KEY[2]. The repeat counter freezes for the 5 edges
        // the channel spends away from a pressed HELD, so repeats after the
        // glitch land 5 cycles later and keep the 10-cycle period.
        t0 = cyc + 1;
        key_a[2] = 1'b0;
        expect_pulse(0, 2, 0, t0 + 10);
        expect_pulse(0, 2, 2, t0 + 50);
        expect_pulse(0, 2, 2, t0 + 65);
        expect_pulse(0, 2, 2, t0 + 75);
        expect_pulse(0, 2, 2, t0 + 85);
        wait_until(t0 + 54);
        key_a[2] = 1'b1;                       // high sampled t0+55..t0+58
        wait_until(t0 + 58);
        key_a[2] = 1'b0;
        wait_until(t0 + 60);
        chk("glitch lvl2 during", a_lvl[2], 1);
        wait_until(t0 + 62);
        chk("glitch lvl2 after", a_lvl[2], 1);
        wait_until(t0 + 89);
        key_a[2] = 1'b1;                       // first sampled at t0+90
        expect_pulse(0, 2, 1, t0 + 100);
        wait_until(t0 + 110);
        chk("glitch lvl2 released", a_lvl[2], 0);

        // Reset mid-hold on KEY[3]; key stays pressed through reset.
        t0 = cyc + 1;
        key_a[3] = 1'b0;
        expect_pulse(0, 3, 0, t0 + 10);
        wait_until(t0 + 20);
        chk("rst lvl3 before", a_lvl[3], 1);
        resetn = 1'b0;
        #1;
        chk("rst lvl immediate", a_lvl, 0);
        chk("rst pulses immediate", {a_prs, a_rel, a_rep}, 0);
        wait_until(t0 + 23);
        resetn = 1'b1;                         // first sampled edge t0+24
        expect_pulse(0, 3, 0, t0 + 34);
        wait_until(t0 + 33);
        chk("rst lvl3 before re-press", a_lvl[3], 0);
        wait_until(t0 + 40);
        chk("rst lvl3 re-pressed", a_lvl[3], 1);
        key_a[3] = 1'b1;                       // first sampled at t0+41
        expect_pulse(0, 3, 1, t0 + 51);
        wait_until(t0 + 60);
        chk("rst lvl3 released", a_lvl[3], 0);

        // Four simultaneous presses on dut B (no auto-repeat), plus switches.
        t0 = cyc + 1;
        key_b = 4'h0;
        for (int k = 0; k < 4; k++) begin
            expect_pulse(1, k, 0, t0 + 10);
            expect_pulse(1, k, 1, t0 + 70);
        end
        wait_until(t0 + 20);
        c = cyc;
        sw_a = 10'h2A5;
        wait_until(c + 1);
        chk("sw one flop", a_sw, 10'h000);
        wait_until(c + 2);
        chk("sw 0x2A5", a_sw, 10'h2A5);
        sw_a = 10'h15A;
        wait_until(c + 4);
        chk("sw 0x15A", a_sw, 10'h15A);
        wait_until(t0 + 55);
        chk("concurrent lvl held", b_lvl, 4'hF);
        wait_until(t0 + 59);
        key_b = 4'hF;                          // first sampled at t0+60
        wait_until(t0 + 80);
        chk("concurrent lvl released", b_lvl, 4'h0);

        // Any expected pulse the monitor never matched.
        wait_until(cyc + 5);
        foreach (sb[i]) begin
            n_chk++;
            n_fail++;
            $display("FAIL pulse dut%0d key%0d %s: missing, required at cycle %0d",
                     sb[i].d, sb[i].k, kname[sb[i].kind], sb[i].c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL take parameter N_KEYS, default 4: number of pushbutton channels.
REQ-002 The block SHALL take parameter N_SW, default 10: number of slide-switch inputs.
REQ-003 The block SHALL take parameter DEBOUNCE_CYC, default 500000: stable-input cycles required, 10 ms at 50 MHz.
REQ-004 The block SHALL take parameter REPEAT_DELAY_CYC, default 25000000: hold time before the first auto-repeat, 500 ms.
REQ-005 The block SHALL take parameter REPEAT_PERIOD_CYC, default 5000000: interval between later repeats, 100 ms.
REQ-006 The block SHALL take parameter REPEAT_EN, default 1: 0 disables auto-repeat.
REQ-007 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-009 The block SHALL have port KEY, input, N_KEYS bits: raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-010 The block SHALL have port SW, input, N_SW bits: raw switches, asynchronous.
REQ-011 The block SHALL have port key_level, output, N_KEYS bits: debounced state per key, 1 = pressed.
REQ-012 The block SHALL have port key_press, output, N_KEYS bits: one-cycle pulse when a key is accepted as pressed.
REQ-013 The block SHALL have port key_release, output, N_KEYS bits: one-cycle pulse when a key is accepted as released.
REQ-014 The block SHALL have port key_repeat, output, N_KEYS bits: one-cycle auto-repeat pulse while a key is held.
REQ-015 The block SHALL have port sw_sync, output, N_SW bits: switches after the synchronizer.

Function
REQ-016 Each KEY and SW bit SHALL pass through a 2-flop synchronizer; raw_pressed = inverted synchronized KEY.
REQ-017 The keys SHALL be independent channels, each with a private FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-018 In IDLE, raw_pressed=1 SHALL move the channel to PRESS_WAIT with its debounce counter cleared.
REQ-019 In PRESS_WAIT, the counter SHALL increment each cycle raw_pressed=1; raw_pressed=0 returns the channel to IDLE with no pulse.
REQ-020 When the counter reaches DEBOUNCE_CYC-1, the channel SHALL enter HELD, assert key_level and pulse key_press for one cycle.
REQ-021 Press latency, from the first clock edge sampling KEY=0 to the key_press pulse, SHALL be exactly DEBOUNCE_CYC+2 cycles for a stable input.
REQ-022 In HELD with REPEAT_EN=1, the repeat counter SHALL pulse key_repeat at REPEAT_DELAY_CYC cycles after key_press, then every REPEAT_PERIOD_CYC cycles.
REQ-023 In HELD, raw_pressed=0 SHALL move the channel to RELEASE_WAIT with the debounce counter cleared and the repeat counter frozen.
REQ-024 In RELEASE_WAIT, raw_pressed=1 SHALL return the channel to HELD, resuming the repeat counter without a new key_press.
REQ-025 In RELEASE_WAIT, a stable release for DEBOUNCE_CYC cycles SHALL clear key_level, pulse key_release and return the channel to IDLE.
REQ-026 key_press, key_release and key_repeat SHALL never assert in the same cycle for one key; key_repeat SHALL never assert with key_level=0.
REQ-027 Counter widths SHALL be $clog2 of the largest cycle parameter plus 1; counters SHALL saturate and never wrap.
REQ-028 Simultaneous activity on several keys SHALL be handled independently, and coincident pulses on different keys are legal.
REQ-029 All outputs SHALL be registered, with no combinational path from KEY or SW to any output.

Reset
REQ-030 While resetn=0, all FSMs SHALL be in IDLE, counters 0, and key_level, key_press, key_release, key_repeat all 0.
REQ-031 While resetn=0, KEY synchronizer flops SHALL be 1 (released) and SW synchronizer flops and sw_sync SHALL be 0.
REQ-032 Reset asserted mid-press SHALL abort the channel with no key_release pulse.
REQ-033 A key held through reset release SHALL be debounced from IDLE afresh.

Structure
REQ-034 A shared package key_pkg SHALL hold the channel state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the default cycle constants.
REQ-035 One sub-module, key_channel (synchronized input in; level and pulses out; counters plus FSM), SHALL be instantiated N_KEYS times by a generate loop.
REQ-036 The top level SHALL contain only the synchronizers and the generate loop.

Verification (bench parameters: DEBOUNCE_CYC=8, REPEAT_DELAY_CYC=40, REPEAT_PERIOD_CYC=10)
REQ-037 Clean press: KEY[0] driven 1->0 and held 100 cycles -> key_press[0] pulses at cycle 10, key_level[0]=1, key_repeat[0] pulses at cycles 50, 60, 70, 80, 90, 100.
REQ-038 Bounce: KEY[1] toggled every 3 cycles for 30 cycles, then held 0 -> no pulse during toggling, exactly one key_press[1] 10 cycles after the toggling stops.
REQ-039 Release glitch: KEY[2] held pressed, one 4-cycle high glitch -> no key_release[2], key_level[2] stays 1, repeat cadence unchanged; then a 20-cycle release -> a single key_release[2].
REQ-040 Reset mid-hold: resetn pulsed low during HELD -> all outputs 0 immediately, no release pulse; with the key still held after reset release, key_press pulses again 10 cycles later.
REQ-041 Concurrency and switches: KEY[3:0]=0000 in one cycle, with REPEAT_EN=0 -> four simultaneous key_press pulses, no key_repeat; SW=0x2A5 -> sw_sync=0x2A5 two cycles later.
